// File: rtl/microc_pkg.sv
// Shared definitions for the microcontroller fetch path: PC operation codes
// and the width helper for return-stack pointers.
package microc_pkg;

  typedef enum logic [1:0] {
    PC_INC  = 2'b00,
    PC_JMP  = 2'b01,
    PC_CALL = 2'b10,
    PC_RET  = 2'b11
  } pc_op_t;

  // A stack of `depth` entries needs to count 0..depth inclusive.
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address stack: LIFO register array with an occupancy
// pointer. Pushes when full and pops when empty are ignored.
module ret_stack
  import microc_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [AW-1:0]                din,
  output logic [AW-1:0]                top,
  output logic [sp_width(DEPTH)-1:0]   sp,
  output logic                         empty,
  output logic                         full
);

  localparam int SPW = sp_width(DEPTH);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]  mem [DEPTH];
  logic [SPW-1:0] sp_q;
  logic           do_push;
  logic           do_pop;
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  top_idx;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == SPW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_idx  = IW'(sp_q);
  assign top_idx = IW'(sp_q - SPW'(1));
  assign top     = empty ? '0 : mem[top_idx];
  assign sp      = sp_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= '0;
    end else if (do_push) begin
      sp_q <= sp_q + SPW'(1);
    end else if (do_pop) begin
      sp_q <= sp_q - SPW'(1);
    end
  end

  // NOTE: the entry array is deliberately not reset; sp = 0 already marks
  // every entry invalid, and leaving it out keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: PC register, next-PC selection (INC/JMP/CALL/RET),
// sticky stack-error flags and stall gating around the return-address stack.
module pc_seq
  import microc_pkg::*;
#(
  parameter int            AW       = 10,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [1:0]                   pc_op,
  input  logic [AW-1:0]                jump_addr,
  output logic [AW-1:0]                pc,
  output logic [sp_width(DEPTH)-1:0]   sp,
  output logic                         stk_empty,
  output logic                         stk_full,
  output logic                         ovf,
  output logic                         unf
);

  pc_op_t        op;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] stk_top;
  logic          push;
  logic          pop;
  logic          ovf_set;
  logic          unf_set;

  assign op     = pc_op_t'(pc_op);
  assign pc_inc = pc_q + AW'(1);
  assign pc     = pc_q;

  ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (stk_top),
    .sp    (sp),
    .empty (stk_empty),
    .full  (stk_full)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    pc_next = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!stall) begin
      case (op)
        PC_INC: pc_next = pc_inc;
        PC_JMP: pc_next = jump_addr;
        PC_CALL: begin
          pc_next = jump_addr;
          push    = 1'b1;
          ovf_set = stk_full;
        end
        PC_RET: begin
          if (stk_empty) begin
            unf_set = 1'b1;
          end else begin
            pop     = 1'b1;
            pc_next = stk_top;
          end
        end
        default: pc_next = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else if (!stall) begin
      pc_q <= pc_next;
      ovf  <= ovf | ovf_set;
      unf  <= unf | unf_set;
    end
  end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer for the single-cycle microcontroller. It holds the PC and selects the next address: increment, jump, subroutine call or return. A hardware return-address stack supports nested calls, and a stall input freezes fetch. Its `pc` output drives the program memory address directly.

## Interface
Parameters:
- `AW`, default 10: PC / address width in bits.
- `DEPTH`, default 4: return-stack entries, ≥1.
- `RESET_PC`, default 0: PC value after reset, `AW` bits.

Ports:
- `clk` in, 1: single clock; all state updates on its rising edge.
- `reset` in, 1: synchronous, active-high.
- `stall` in, 1: when 1, all state holds and `pc_op` is ignored.
- `pc_op` in, 2: next-PC operation; 00 INC, 01 JMP, 10 CALL, 11 RET.
- `jump_addr` in, AW: target for JMP and CALL.
- `pc` out, AW: current PC, registered.
- `sp` out, $clog2(DEPTH+1): number of valid stack entries.
- `stk_empty` out, 1: `sp == 0`, combinational from `sp`.
- `stk_full` out, 1: `sp == DEPTH`, combinational from `sp`.
- `ovf` out, 1: sticky; set by a CALL attempted while the stack is full.
- `unf` out, 1: sticky; set by a RET attempted while the stack is empty.

## Operation
- Reset values: `pc = RESET_PC`, `sp = 0`, `ovf = 0`, `unf = 0`. Stack contents are don't-care.
- Priority: `reset` > `stall` > `pc_op`.
- Increment value `pc_inc` = (`pc` + 1) mod 2^AW. The all-ones PC wraps to 0.
- INC: `pc <= pc_inc`.
- JMP: `pc <= jump_addr`. Stack unchanged.
- CALL, not full:
  - Push `pc_inc` onto the stack.
  - `sp <= sp + 1`.
  - `pc <= jump_addr`.
- CALL, full:
  - `pc <= jump_addr`.
  - No push; stack and `sp` unchanged.
  - `ovf <= 1`.
- RET, not empty:
  - `pc <= top of stack`.
  - `sp <= sp - 1`.
- RET, empty:
  - `pc <= pc_inc`.
  - `sp` stays 0.
  - `unf <= 1`.
- Stack is LIFO: the top is the entry written most recently and not yet popped.
- `ovf` and `unf` clear only on `reset`.

## Timing
- One-cycle latency: an op sampled at edge N is visible on `pc` and `sp` after edge N.
- A RET immediately after a CALL returns the address pushed by that CALL. No bypass is needed, because the push is committed at the CALL edge.
- Stall:
  - `stall` high for K cycles holds `pc`, `sp`, the stack and the flags for K edges.
  - The op is not queued; it is lost.
- Reset mid-operation: `reset` asserted with any `stall` or `pc_op` value gives the reset values after that edge. Stack contents are discarded logically, because `sp = 0`.
- No combinational path from inputs to `pc`. `stk_empty` and `stk_full` depend only on `sp`.

## Structure
- Shared package `microc_pkg` holds:
  - the `pc_op_t` enum: `PC_INC`, `PC_JMP`, `PC_CALL`, `PC_RET`;
  - a width helper for `sp`.
- Sub-module `ret_stack`, parametrised by `AW` and `DEPTH`:
  - register array plus `sp`;
  - inputs `push`, `pop`, `din`;
  - outputs `top`, `sp`, `empty`, `full`;
  - ignores `push` when full and `pop` when empty.
- `pc_seq` holds:
  - the PC register;
  - the increment adder;
  - the next-PC mux;
  - the sticky flags;
  - the gating that maps `stall` and `pc_op` onto `push` / `pop`.

## Test plan
All scenarios use AW=10, DEPTH=4, RESET_PC=0.
- **Reset / INC:** reset, then 3× INC → `pc` = 0, 1, 2, 3; `sp` = 0; flags 0. Set `pc` to 0x3FF, then INC → `pc` = 0x000.
- **Call / return:** at `pc` = 5, CALL 0x100 → `pc` = 0x100, `sp` = 1. INC, then RET → `pc` = 6, `sp` = 0. Repeat with a nested CALL 0x200 issued at 0x101: the two RETs give 0x102, then 6.
- **Overflow:** 4 CALLs from `pc` = 0x10, 0x20, 0x30, 0x40 → `stk_full` = 1.
  - A 5th CALL 0x300 → `pc` = 0x300, `sp` = 4, `ovf` = 1.
  - The next 4 RETs give 0x41, 0x31, 0x21, 0x11.
- **Underflow:** with `sp` = 0 and `pc` = 7, RET → `pc` = 8, `unf` = 1.
  - `unf` stays 1 through 10 more cycles of ops.
  - `unf` clears only on reset.
- **Stall:** at `pc` = 0x20, `sp` = 1, drive `stall` = 1 with RET for 3 cycles → `pc`, `sp` unchanged. Release `stall` with INC → `pc` = 0x21.
- **Reset mid-op:** with `sp` = 3 and `ovf` = 1, assert `reset` together with CALL → `pc` = 0, `sp` = 0, `ovf` = 0, `unf` = 0. A following RET → `unf` = 1, `pc` = 1.
